up_down_counter_param: RTL and testbench
========================================

Name: up_down_counter_param

Overview:
Parametrised successor of the team's 4-bit up/down counter. Width is configurable and the count runs between programmable min/max limits with a programmable step. At a limit the counter either wraps or saturates, selectable at runtime. Adds synchronous clear, parallel load, count enable, a terminal-count pulse and sticky overflow/underflow flags, for use as a general event, timer or address counter in datapath blocks.

Parameters:
WIDTH, 8, counter and limit width in bits (≥2)
RST_VAL, 0, count value applied by reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
en  input  1  count enable; count changes only when high (except clear/load)
mode  input  1  direction: 1 = up, 0 = down
wrap  input  1  1 = wrap at limit, 0 = saturate at limit
clear  input  1  synchronous clear of count to min_val and of sticky flags
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
step  input  WIDTH  increment/decrement amount; 0 treated as 1
min_val  input  WIDTH  lower limit, inclusive
max_val  input  WIDTH  upper limit, inclusive
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle pulse when a counting step hits or crosses a limit
at_max  output  1  combinational: count == max_val
at_min  output  1  combinational: count == min_val
ovf  output  1  sticky: set on up-step crossing max_val
unf  output  1  sticky: set on down-step crossing min_val
cfg_err  output  1  combinational: min_val > max_val

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset is low: count = RST_VAL, tc = 0, ovf = 0, unf = 0. Deassertion is sampled on the next clk edge.
- Priority per edge: clear > load > en. If none is active, count holds and tc = 0.
- clear: count <= min_val; ovf and unf <= 0; tc <= 0.
- load: count <= load_val, clamped into [min_val, max_val]; tc <= 0; flags unchanged.
- Counting (en=1), effective step s = (step==0 ? 1 : step). Arithmetic is done in WIDTH+1 bits, so there is no native wrap-around.
  - Up, count + s ≤ max_val: count <= count + s.
  - Up, count + s > max_val (including count already above max_val): tc <= 1; ovf <= 1; count <= min_val if wrap=1, else max_val.
  - Down, count ≥ min_val + s: count <= count − s.
  - Down otherwise (including count already below min_val): tc <= 1; unf <= 1; count <= max_val if wrap=1, else min_val.
  - Saturate mode holding at a limit: further steps re-pulse tc every enabled cycle. ovf/unf remain set.
- tc is registered: high exactly one cycle after the boundary edge, and high again only if the next enabled step is also a boundary step.
- cfg_err=1: counting is suppressed (count holds, tc = 0). clear and load still act; load takes load_val unclamped.
- mode, wrap, step and the limits may change on any cycle. They take effect on the next edge and have no pipeline.
- Latency: one clk from control input to count. at_max, at_min and cfg_err are combinational from count and the limits.

Decomposition:
- Package up_down_counter_pkg holds:
  - MODE_UP = 1'b1, MODE_DOWN = 1'b0
  - WRAP = 1'b1, SAT = 1'b0
  - an enum for next-value source {HOLD, INC, DEC, TO_MIN, TO_MAX, LOAD, CLR}
- One combinational sub-module, udc_next_calc, computes the next-value source, the next count, and the tc/ovf/unf set terms from count, the controls and the limits. The top level holds only the registers and the flag logic.

Test Plan:
All scenarios use WIDTH=4, RST_VAL=0.
1. Reset low mid-count (count=9) → count=0, tc/ovf/unf=0 immediately, without waiting for clk. Release, then en=1, mode=1, step=1, min=0, max=15 → count 1,2,3 on successive edges.
2. min=2, max=10, step=3, wrap=1, up from 2 → 5, 8, then 2 with tc=1 for one cycle and ovf=1. Continue → 5 with tc=0 and ovf still 1.
3. Same limits, wrap=0, down from 4 with step=3 → 2 with tc=1 and unf=1. Next edge → 2 with tc=1 again. clear → count=2, unf=0.
4. load=1, load_val=14 with min=2, max=10 → count=10 (clamped), at_max=1. load and clear together → count=min_val=2.
5. step=0, up from 5 → 6 (treated as 1). min=12, max=3 → cfg_err=1; en=1 for 3 cycles → count holds, tc=0.
6. Count already at 12 after max changed to 10, mode=1, wrap=1 → next edge count=min_val, tc=1, ovf=1.

Source files
------------

// File: rtl/up_down_counter_pkg.sv
// Shared constants and the next-value source encoding for the parametrised
// up/down counter.
package up_down_counter_pkg;

   localparam logic MODE_UP   = 1'b1;
   localparam logic MODE_DOWN = 1'b0;
   localparam logic WRAP      = 1'b1;
   localparam logic SAT       = 1'b0;

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      INC    = 3'd1,
      DEC    = 3'd2,
      TO_MIN = 3'd3,
      TO_MAX = 3'd4,
      LOAD   = 3'd5,
      CLR    = 3'd6
   } nxt_src_e;

endpackage

// File: rtl/udc_next_calc.sv
// Combinational next-state logic for the up/down counter: picks the source of
// the next count and raises the terminal-count and overflow/underflow set terms.
module udc_next_calc
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  logic             en,
   input  logic             mode,
   input  logic             wrap,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] min_val,
   input  logic [WIDTH-1:0] max_val,
   output nxt_src_e         src,
   output logic [WIDTH-1:0] nxt_count,
   output logic             tc_set,
   output logic             ovf_set,
   output logic             unf_set,
   output logic             cfg_err
);

   logic [WIDTH-1:0] step_eff_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   min_plus_s;
   logic [WIDTH-1:0] load_clamp_s;

   // One extra bit keeps the limit compares free of native wrap-around.
   assign step_eff_s = (step == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : step;
   assign sum_s      = {1'b0, count} + {1'b0, step_eff_s};
   assign min_plus_s = {1'b0, min_val} + {1'b0, step_eff_s};
   assign cfg_err    = (min_val > max_val);

   // Source selection with clear > load > en priority.
   always_comb begin
      src     = HOLD;
      tc_set  = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (clear) begin
         src = CLR;
      end else if (load) begin
         src = LOAD;
      end else if (en && !cfg_err) begin
         if (mode == MODE_UP) begin
            if (sum_s > {1'b0, max_val}) begin
               src     = (wrap == WRAP) ? TO_MIN : TO_MAX;
               tc_set  = 1'b1;
               ovf_set = 1'b1;
            end else begin
               src = INC;
            end
         end else begin
            if ({1'b0, count} >= min_plus_s) begin
               src = DEC;
            end else begin
               src     = (wrap == WRAP) ? TO_MAX : TO_MIN;
               tc_set  = 1'b1;
               unf_set = 1'b1;
            end
         end
      end else begin
         src = HOLD;
      end
   end

   // Loads are clamped into the window unless the window itself is inverted.
   always_comb begin
      load_clamp_s = load_val;
      if (cfg_err) begin
         load_clamp_s = load_val;
      end else if (load_val < min_val) begin
         load_clamp_s = min_val;
      end else if (load_val > max_val) begin
         load_clamp_s = max_val;
      end else begin
         load_clamp_s = load_val;
      end
   end

   // Next count value mux.
   always_comb begin
      nxt_count = count;
      case (src)
         HOLD:    nxt_count = count;
         INC:     nxt_count = sum_s[WIDTH-1:0];
         DEC:     nxt_count = count - step_eff_s;
         TO_MIN:  nxt_count = min_val;
         TO_MAX:  nxt_count = max_val;
         LOAD:    nxt_count = load_clamp_s;
         CLR:     nxt_count = min_val;
         default: nxt_count = count;
      endcase
   end

endmodule

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with programmable limits and step, wrap or
// saturate at the limits, terminal-count pulse and sticky overflow/underflow.
module up_down_counter_param
   import up_down_counter_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             wrap,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] min_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min,
   output logic             ovf,
   output logic             unf,
   output logic             cfg_err
);

   logic [WIDTH-1:0] count_r;
   logic             tc_r;
   logic             ovf_r;
   logic             unf_r;
   nxt_src_e         src_s;
   logic [WIDTH-1:0] nxt_count_s;
   logic             tc_set_s;
   logic             ovf_set_s;
   logic             unf_set_s;
   logic             cfg_err_s;

   udc_next_calc #(
      .WIDTH (WIDTH)
   ) u_next_calc (
      .count     (count_r),
      .en        (en),
      .mode      (mode),
      .wrap      (wrap),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .step      (step),
      .min_val   (min_val),
      .max_val   (max_val),
      .src       (src_s),
      .nxt_count (nxt_count_s),
      .tc_set    (tc_set_s),
      .ovf_set   (ovf_set_s),
      .unf_set   (unf_set_s),
      .cfg_err   (cfg_err_s)
   );

   // Count, terminal-count pulse and sticky flags; clear drops the flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= RST_VAL;
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         count_r <= nxt_count_s;
         tc_r    <= tc_set_s;
         if (src_s == CLR) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
         end else begin
            ovf_r <= ovf_r | ovf_set_s;
            unf_r <= unf_r | unf_set_s;
         end
      end
   end

   assign count   = count_r;
   assign tc      = tc_r;
   assign ovf     = ovf_r;
   assign unf     = unf_r;
   assign at_max  = (count_r == max_val);
   assign at_min  = (count_r == min_val);
   assign cfg_err = cfg_err_s;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Table-driven bench for up_down_counter_param (WIDTH=4) with an expected-value
// queue popped one cycle after each vector is driven.
module tb_up_down_counter_param;

   logic       clk;
   logic       reset;
   logic       en;
   logic       mode;
   logic       wrap;
   logic       clear;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] step;
   logic [3:0] min_val;
   logic [3:0] max_val;
   logic [3:0] count;
   logic       tc;
   logic       at_max;
   logic       at_min;
   logic       ovf;
   logic       unf;
   logic       cfg_err;

   int checks;
   int errors;

   typedef struct packed {
      logic       v_en;
      logic       v_mode;
      logic       v_wrap;
      logic       v_clear;
      logic       v_load;
      logic [3:0] v_load_val;
      logic [3:0] v_step;
      logic [3:0] v_min;
      logic [3:0] v_max;
      logic [3:0] e_count;
      logic       e_tc;
      logic       e_ovf;
      logic       e_unf;
      logic       e_amax;
      logic       e_amin;
      logic       e_cerr;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   up_down_counter_param #(
      .WIDTH   (4),
      .RST_VAL (4'd0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .wrap     (wrap),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .step     (step),
      .min_val  (min_val),
      .max_val  (max_val),
      .count    (count),
      .tc       (tc),
      .at_max   (at_max),
      .at_min   (at_min),
      .ovf      (ovf),
      .unf      (unf),
      .cfg_err  (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   // ctl = {en, mode, wrap, clear, load}; ef = {tc, ovf, unf, at_max, at_min, cfg_err}
   function automatic vec_t mk(input logic [4:0] ctl, input logic [3:0] lv, input logic [3:0] st,
                               input logic [3:0] mn, input logic [3:0] mx, input logic [3:0] ec,
                               input logic [5:0] ef);
      vec_t v;
      v = {ctl, lv, st, mn, mx, ec, ef};
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec %0d actual %0h required %0h", name, idx, act, req);
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      en       = v.v_en;
      mode     = v.v_mode;
      wrap     = v.v_wrap;
      clear    = v.v_clear;
      load     = v.v_load;
      load_val = v.v_load_val;
      step     = v.v_step;
      min_val  = v.v_min;
      max_val  = v.v_max;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("count",   idx, {4'd0, count},   {4'd0, e.e_count});
      chk("tc",      idx, {7'd0, tc},      {7'd0, e.e_tc});
      chk("ovf",     idx, {7'd0, ovf},     {7'd0, e.e_ovf});
      chk("unf",     idx, {7'd0, unf},     {7'd0, e.e_unf});
      chk("at_max",  idx, {7'd0, at_max},  {7'd0, e.e_amax});
      chk("at_min",  idx, {7'd0, at_min},  {7'd0, e.e_amin});
      chk("cfg_err", idx, {7'd0, cfg_err}, {7'd0, e.e_cerr});
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         apply(i, tbl[i]);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      en       = 1'b0;
      mode     = 1'b0;
      wrap     = 1'b0;
      clear    = 1'b0;
      load     = 1'b0;
      load_val = 4'd0;
      step     = 4'd1;
      min_val  = 4'd0;
      max_val  = 4'd15;

      // 0..2: set ovf, park at 9 before the mid-count reset
      tbl.push_back(mk(5'b00001, 4'd15, 4'd1, 4'd0,  4'd15, 4'd15, 6'b000100));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd0,  4'd15, 4'd0,  6'b110010));
      tbl.push_back(mk(5'b00001, 4'd9,  4'd1, 4'd0,  4'd15, 4'd9,  6'b010000));
      // 3..5: plain up count after reset
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd0,  4'd15, 4'd1,  6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd0,  4'd15, 4'd2,  6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd0,  4'd15, 4'd3,  6'b000000));
      // 6..10: window [2,10], step 3, wrap up
      tbl.push_back(mk(5'b00001, 4'd2,  4'd3, 4'd2,  4'd10, 4'd2,  6'b000010));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd3, 4'd2,  4'd10, 4'd5,  6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd3, 4'd2,  4'd10, 4'd8,  6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd3, 4'd2,  4'd10, 4'd2,  6'b110010));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd3, 4'd2,  4'd10, 4'd5,  6'b010000));
      // 11..14: saturating down, repeated tc, then clear
      tbl.push_back(mk(5'b00001, 4'd4,  4'd3, 4'd2,  4'd10, 4'd4,  6'b010000));
      tbl.push_back(mk(5'b10000, 4'd0,  4'd3, 4'd2,  4'd10, 4'd2,  6'b111010));
      tbl.push_back(mk(5'b10000, 4'd0,  4'd3, 4'd2,  4'd10, 4'd2,  6'b111010));
      tbl.push_back(mk(5'b00010, 4'd0,  4'd3, 4'd2,  4'd10, 4'd2,  6'b000010));
      // 15..16: clamped load, clear beats load
      tbl.push_back(mk(5'b00001, 4'd14, 4'd3, 4'd2,  4'd10, 4'd10, 6'b000100));
      tbl.push_back(mk(5'b00011, 4'd5,  4'd3, 4'd2,  4'd10, 4'd2,  6'b000010));
      // 17..22: step 0 acts as 1, inverted window freezes counting, unclamped load
      tbl.push_back(mk(5'b00001, 4'd5,  4'd0, 4'd2,  4'd10, 4'd5,  6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd0, 4'd2,  4'd10, 4'd6,  6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd12, 4'd3,  4'd6,  6'b000001));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd12, 4'd3,  4'd6,  6'b000001));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd12, 4'd3,  4'd6,  6'b000001));
      tbl.push_back(mk(5'b00001, 4'd7,  4'd1, 4'd12, 4'd3,  4'd7,  6'b000001));
      // 23..26: count above a lowered max, then down-wrap from min
      tbl.push_back(mk(5'b00001, 4'd12, 4'd1, 4'd0,  4'd15, 4'd12, 6'b000000));
      tbl.push_back(mk(5'b11100, 4'd0,  4'd1, 4'd2,  4'd10, 4'd2,  6'b110010));
      tbl.push_back(mk(5'b10100, 4'd0,  4'd1, 4'd2,  4'd10, 4'd10, 6'b111100));
      tbl.push_back(mk(5'b10100, 4'd0,  4'd4, 4'd2,  4'd10, 4'd6,  6'b011000));

      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", -1, {4'd0, count}, 8'd0);
      chk("rst_tc",    -1, {7'd0, tc},    8'd0);
      chk("rst_ovf",   -1, {7'd0, ovf},   8'd0);
      chk("rst_unf",   -1, {7'd0, unf},   8'd0);
      @(negedge clk);
      reset = 1'b1;

      run_range(0, 2);

      // Asynchronous reset between edges must take effect immediately.
      #2;
      reset = 1'b0;
      #1;
      chk("async_count", -2, {4'd0, count}, 8'd0);
      chk("async_tc",    -2, {7'd0, tc},    8'd0);
      chk("async_ovf",   -2, {7'd0, ovf},   8'd0);
      chk("async_unf",   -2, {7'd0, unf},   8'd0);
      @(negedge clk);
      reset = 1'b1;

      run_range(3, tbl.size() - 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
